adjust_ctrl: RTL
================

# adjust_ctrl

Key-driven time/alarm adjustment controller for the digital clock. Debounces the mode and increment push-buttons, steps a mode state machine (run, set hour, set minute, set alarm hour, set alarm minute), and issues single-cycle increment pulses with auto-repeat to the hour/minute counters and alarm registers. It also gates the seconds counter, drives the display blink phase, and returns to run mode on inactivity.

## Interface
- DB_CYCLES, 1000000, stable-level cycles required to accept a key change (20 ms at 50 MHz)
- REPEAT_DLY, 25000000, cycles from first increment pulse to first auto-repeat pulse
- REPEAT_PER, 10000000, cycles between subsequent auto-repeat pulses
- TIMEOUT_S, 30, Tick1Hz pulses without a key press before forced return to RUN (1..63)

- CP50  in  1  system clock, 50 MHz, rising edge
- nCR  in  1  asynchronous active-low reset
- Tick1Hz  in  1  one-cycle pulse per second from the clock divider
- KeyMode  in  1  raw mode button, active high, asynchronous
- KeyInc  in  1  raw increment button, active high, asynchronous
- Mode  out  3  current state: 0 RUN, 1 SET_H, 2 SET_M, 3 ALM_H, 4 ALM_M
- IncH / IncM  out  1  one-cycle increment pulse to time hour / minute counter
- AlmIncH / AlmIncM  out  1  one-cycle increment pulse to alarm hour / minute register
- CntEN  out  1  seconds counter enable; 1 only in RUN
- ClrSec  out  1  one-cycle pulse clearing seconds when leaving SET_M
- Blink  out  1  display blank phase for the field being adjusted

## Operation
- Each key: two-flop synchronizer, then debounce counter; counter runs while synced level differs from debounced level, clears when equal; at DB_CYCLES consecutive differing cycles the debounced level takes the synced value.
- Press event = registered rising edge of debounced level; releases generate no event.
- Mode press: RUN→SET_H→SET_M→ALM_H→ALM_M→RUN. No auto-repeat on KeyMode.
- Inc press in SET_H/SET_M/ALM_H/ALM_M pulses IncH/IncM/AlmIncH/AlmIncM respectively; in RUN it is ignored.
- Auto-repeat: while debounced KeyInc stays high in an adjust state, repeat pulse REPEAT_DLY cycles after the initial pulse, then every REPEAT_PER cycles. Repeat counter clears on release or any mode change.
- Timeout: 6-bit counter counts Tick1Hz in non-RUN states; cleared by any press event or on entering RUN; reaching TIMEOUT_S forces RUN.
- Blink toggles on each Tick1Hz in non-RUN states; held 0 in RUN; forced 0 in the cycle of any Inc pulse and the toggle phase restarts there.
- Leaving SET_M (by Mode press or timeout) pulses ClrSec once.
- Simultaneous events: Mode press beats Inc press/repeat in the same cycle (Inc discarded, repeat counter cleared); press event beats timeout expiry; Tick1Hz coinciding with a press does not advance timeout.
- Internal counters 25 bits; DB_CYCLES, REPEAT_DLY, REPEAT_PER each in 1..2^25-1.

## Timing
- Reset: Mode=0, CntEN=1, all pulse outputs 0, Blink=0, synchronizer, debounced levels and all counters 0.
- Key latency: with edge 0 the first CP50 edge sampling the raw key high and the key held stable, debounced level rises at edge DB_CYCLES+2; press pulse (Mode change or Inc pulse) is visible after edge DB_CYCLES+3, high for exactly one cycle.
- Mode, CntEN and ClrSec update in the same cycle as the Mode press pulse.
- Key held through reset release registers as a fresh press after DB_CYCLES+3 edges.
- Reset asserted mid-adjust: immediate return to RUN, no pulse emitted.

## Configuration
- ADJ_ALARM_EN defined: five states as above.
- Undefined: ALM_H/ALM_M removed; SET_M→RUN on Mode press; AlmIncH/AlmIncM tied 0; Mode never exceeds 2.

## Test plan
Bench params: DB_CYCLES=4, REPEAT_DLY=20, REPEAT_PER=8, TIMEOUT_S=3.
- Reset then KeyMode high 10 cycles → Mode 0→1 after edge 7; CntEN falls same cycle; no Inc pulses.
- KeyMode pulse 3 cycles (bounce) → no state change; later 6-cycle press → one transition.
- In SET_H, KeyInc held 50 cycles → IncH pulses at edges 7, 27, 35, 43; stops on release.
- In SET_M, press Mode → Mode=3 (ADJ_ALARM_EN) or 0 (undefined), ClrSec one cycle, CntEN=1 only when Mode=0.
- In SET_H, 3 Tick1Hz pulses with no key → Mode=0; with a press after 2 ticks → stays SET_H.
- KeyMode and KeyInc rise same cycle in SET_H → Mode=2, no IncH pulse.

Source files
------------

// File: rtl/adjust_ctrl_if.sv
// Key inputs and adjust pulses exchanged between the front panel and adjust_ctrl.
// master drives keys and the 1 Hz tick; slave is the controller.
interface adjust_ctrl_if;
    logic       tick_1hz;
    logic       key_mode;
    logic       key_inc;
    logic [2:0] mode;
    logic       inc_h;
    logic       inc_m;
    logic       alm_inc_h;
    logic       alm_inc_m;
    logic       cnt_en;
    logic       clr_sec;
    logic       blink;

    modport master (
        output tick_1hz, key_mode, key_inc,
        input  mode, inc_h, inc_m, alm_inc_h, alm_inc_m, cnt_en, clr_sec, blink
    );

    modport slave (
        input  tick_1hz, key_mode, key_inc,
        output mode, inc_h, inc_m, alm_inc_h, alm_inc_m, cnt_en, clr_sec, blink
    );
endinterface

// File: rtl/adjust_ctrl.sv
// Time/alarm adjust controller: key debounce, mode FSM, increment pulses with auto-repeat.
// Define ADJ_ALARM_EN to include the alarm hour/minute adjust states.
module adjust_ctrl #(
    parameter int unsigned DbCycles  = 1000000,
    parameter int unsigned RepeatDly = 25000000,
    parameter int unsigned RepeatPer = 10000000,
    parameter int unsigned TimeoutS  = 30
) (
    input logic          clk_i,
    input logic          rst_ni,
    adjust_ctrl_if.slave bus_io
);

    typedef enum logic [2:0] {
        StRun  = 3'd0,
        StSetH = 3'd1,
        StSetM = 3'd2,
        StAlmH = 3'd3,
        StAlmM = 3'd4
    } state_e;

    localparam logic [24:0] DbLim   = 25'(DbCycles);
    localparam logic [24:0] DlyLast = 25'(RepeatDly - 1);
    localparam logic [24:0] PerLast = 25'(RepeatPer - 1);
    localparam logic [5:0]  TmoLast = 6'(TimeoutS - 1);
    localparam int unsigned KMode   = 0;
    localparam int unsigned KInc    = 1;

    logic [1:0]  key_raw;
    logic [1:0]  sync1_q, sync2_q;
    logic [1:0]  deb_q, deb_d, deb_prev_q;
    logic [24:0] db_cnt_q [2];
    logic [24:0] db_cnt_d [2];

    state_e      state_q, state_d;
    logic [24:0] rpt_q, rpt_d;
    logic        arm_q, arm_d;
    logic        first_q, first_d;
    logic [5:0]  tmo_q, tmo_d;
    logic        blink_q, blink_d;
    logic        clr_q, clr_d;
    logic        inc_h_q, inc_h_d;
    logic        inc_m_q, inc_m_d;
    logic        mode_press, inc_press, adjust, fire;

    assign key_raw = {bus_io.key_inc, bus_io.key_mode};

    // Counter runs only while the synced level disagrees with the accepted level.
    always_comb begin
        deb_d = deb_q;
        for (int k = 0; k < 2; k++) begin
            db_cnt_d[k] = '0;
            if (sync2_q[k] != deb_q[k]) begin
                if (db_cnt_q[k] == DbLim) begin
                    deb_d[k] = sync2_q[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + 25'd1;
                end
            end
        end
    end

    assign mode_press = deb_q[KMode] & ~deb_prev_q[KMode];
    assign inc_press  = deb_q[KInc] & ~deb_prev_q[KInc];
    assign adjust     = (state_q != StRun);

    always_comb begin
        state_d = state_q;
        rpt_d   = rpt_q;
        arm_d   = arm_q;
        first_d = first_q;
        tmo_d   = tmo_q;
        blink_d = blink_q;
        clr_d   = 1'b0;
        fire    = 1'b0;

        if (mode_press) begin
            case (state_q)
                StRun:   state_d = StSetH;
                StSetH:  state_d = StSetM;
`ifdef ADJ_ALARM_EN
                StSetM:  state_d = StAlmH;
                StAlmH:  state_d = StAlmM;
`else
                StSetM:  state_d = StRun;
`endif
                default: state_d = StRun;
            endcase
            clr_d   = (state_q == StSetM);
            rpt_d   = '0;
            arm_d   = 1'b0;
            first_d = 1'b0;
            tmo_d   = '0;
        end else if (adjust) begin
            if (inc_press) begin
                fire    = 1'b1;
                arm_d   = 1'b1;
                first_d = 1'b1;
                rpt_d   = '0;
                tmo_d   = '0;
            end else if (arm_q && deb_q[KInc]) begin
                if (rpt_q == (first_q ? DlyLast : PerLast)) begin
                    fire    = 1'b1;
                    first_d = 1'b0;
                    rpt_d   = '0;
                end else begin
                    rpt_d = rpt_q + 25'd1;
                end
            end else begin
                arm_d   = 1'b0;
                first_d = 1'b0;
                rpt_d   = '0;
            end

            // A press in this cycle already cleared the timeout, so the tick is ignored.
            if (!inc_press && bus_io.tick_1hz) begin
                if (tmo_q == TmoLast) begin
                    state_d = StRun;
                    clr_d   = (state_q == StSetM);
                    fire    = 1'b0;
                    arm_d   = 1'b0;
                    first_d = 1'b0;
                    rpt_d   = '0;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + 6'd1;
                end
            end
        end

        if (state_d == StRun) begin
            blink_d = 1'b0;
        end else if (fire) begin
            blink_d = 1'b0;
        end else if (adjust && bus_io.tick_1hz) begin
            blink_d = ~blink_q;
        end

        inc_h_d = fire && (state_q == StSetH);
        inc_m_d = fire && (state_q == StSetM);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            deb_q       <= '0;
            deb_prev_q  <= '0;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
            state_q     <= StRun;
            rpt_q       <= '0;
            arm_q       <= 1'b0;
            first_q     <= 1'b0;
            tmo_q       <= '0;
            blink_q     <= 1'b0;
            clr_q       <= 1'b0;
            inc_h_q     <= 1'b0;
            inc_m_q     <= 1'b0;
        end else begin
            sync1_q     <= key_raw;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            deb_prev_q  <= deb_q;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
            state_q     <= state_d;
            rpt_q       <= rpt_d;
            arm_q       <= arm_d;
            first_q     <= first_d;
            tmo_q       <= tmo_d;
            blink_q     <= blink_d;
            clr_q       <= clr_d;
            inc_h_q     <= inc_h_d;
            inc_m_q     <= inc_m_d;
        end
    end

`ifdef ADJ_ALARM_EN
    logic alm_h_q, alm_m_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            alm_h_q <= 1'b0;
            alm_m_q <= 1'b0;
        end else begin
            alm_h_q <= fire && (state_q == StAlmH);
            alm_m_q <= fire && (state_q == StAlmM);
        end
    end

    assign bus_io.alm_inc_h = alm_h_q;
    assign bus_io.alm_inc_m = alm_m_q;
`else
    assign bus_io.alm_inc_h = 1'b0;
    assign bus_io.alm_inc_m = 1'b0;
`endif

    assign bus_io.mode    = state_q;
    assign bus_io.cnt_en  = (state_q == StRun);
    assign bus_io.clr_sec = clr_q;
    assign bus_io.blink   = blink_q;
    assign bus_io.inc_h   = inc_h_q;
    assign bus_io.inc_m   = inc_m_q;

endmodule
